// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and next-PC redirect logic.
// One-cycle instruction memory; redirects flush IF/ID (no delay slot).
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  NPCOP,
    input  logic [15:0] Imm16,
    input  logic [25:0] JTarget,
    input  logic [31:0] RegTarget,
    input  logic        Stall,
    input  logic        IMemReady,
    input  logic [31:0] IMemData,
    output logic [31:0] IMemAddr,
    output logic [31:0] Instr,
    output logic [5:0]  Opcode,
    output logic [5:0]  Funct,
    output logic [31:0] PCPlus4,
    output logic        Valid,
    output logic [15:0] FlushCnt
);

    typedef enum logic [1:0] {StBoot, StRun, StHold} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_plus4_q, pc_plus4_d;
    logic        valid_q, valid_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;

    logic        redirect;
    logic [31:0] target;

    // NPCOP only means something while IF/ID holds a real instruction.
    assign redirect = valid_q && (NPCOP != 2'b00);

    always_comb begin
        case (NPCOP)
            2'b01:   target = pc_plus4_q + {{14{Imm16[15]}}, Imm16, 2'b00};
            2'b10:   target = {pc_plus4_q[31:28], JTarget, 2'b00};
            default: target = RegTarget;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        pc_plus4_d  = pc_plus4_q;
        valid_d     = valid_q;
        flush_cnt_d = flush_cnt_q;

        case (state_q)
            StBoot: begin
                state_d = StRun;
            end
            default: begin
                if (Stall) begin
                    // Everything holds; redirect waits for the first unstalled cycle.
                end else if (redirect) begin
                    pc_d        = target;
                    instr_d     = 32'h0;
                    valid_d     = 1'b0;
                    flush_cnt_d = (flush_cnt_q == 16'hFFFF) ? flush_cnt_q : flush_cnt_q + 16'd1;
                    // HOLD is only left by a completed normal fetch.
                    if (!IMemReady) begin
                        state_d = StHold;
                    end
                end else if (!IMemReady) begin
                    instr_d = 32'h0;
                    valid_d = 1'b0;
                    state_d = StHold;
                end else begin
                    instr_d    = IMemData;
                    pc_plus4_d = pc_q + 32'd4;
                    pc_d       = pc_q + 32'd4;
                    valid_d    = 1'b1;
                    state_d    = StRun;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StBoot;
            pc_q        <= RESET_PC;
            instr_q     <= 32'h0;
            pc_plus4_q  <= 32'h0;
            valid_q     <= 1'b0;
            flush_cnt_q <= 16'h0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            pc_plus4_q  <= pc_plus4_d;
            valid_q     <= valid_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign IMemAddr = pc_q;
    assign Instr    = instr_q;
    assign Opcode   = instr_q[31:26];
    assign Funct    = instr_q[5:0];
    assign PCPlus4  = pc_plus4_q;
    assign Valid    = valid_q;
    assign FlushCnt = flush_cnt_q;

endmodule
